// File: rtl/nn_stream_pkg.sv
// Shared stream types and default widths for the conv -> requant -> maxpool path.
package nn_stream_pkg;
  localparam int DATAW_D = 8;
  localparam int ACCW_D  = 24;
  localparam int SHW_D   = 5;

  typedef struct packed {
    logic vld;
    logic eol;
    logic eof;
  } frame_tag_t;
endpackage

// File: rtl/requant_round_sat.sv
// Round-shift (S2) and saturate/ReLU (S3) stages, one register per stage,
// with the frame tag travelling alongside the data.
module requant_round_sat
  import nn_stream_pkg::*;
#(
  parameter int DATAW = DATAW_D,
  parameter int ACCW  = ACCW_D,
  parameter int SHW   = SHW_D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  frame_tag_t             in_tag,
  input  logic signed [ACCW:0]   in_sum,
  input  logic        [SHW-1:0]  in_shift,
  input  logic                   in_relu,
  output frame_tag_t             out_tag,
  output logic        [DATAW-1:0] out_data,
  output logic        [15:0]     sat_cnt
);
  localparam logic signed [ACCW+1:0] ONE  = {{(ACCW+1){1'b0}}, 1'b1};
  localparam logic signed [ACCW+1:0] UMAX = {{(ACCW+2-DATAW){1'b0}}, {DATAW{1'b1}}};
  localparam logic signed [ACCW+1:0] SMAX = {{(ACCW+3-DATAW){1'b0}}, {(DATAW-1){1'b1}}};
  localparam logic signed [ACCW+1:0] SMIN = {{(ACCW+3-DATAW){1'b1}}, {(DATAW-1){1'b0}}};

  logic signed [ACCW+1:0] ext, rnd, shr;
  frame_tag_t             s2_tag;
  logic signed [ACCW+1:0] s2_r;
  logic                   s2_relu;
  logic [DATAW-1:0]       sat_val;
  logic                   sat_hit;

  // Shifts wider than the sum collapse to the sign, regardless of rounding.
  always_comb begin
    ext = {in_sum[ACCW], in_sum};
    rnd = '0;
    if (in_shift != '0) rnd = ONE << (in_shift - 1'b1);
    if (int'(in_shift) > ACCW) shr = {(ACCW+2){in_sum[ACCW]}};
    else                       shr = (ext + rnd) >>> in_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_tag  <= '0;
      s2_r    <= '0;
      s2_relu <= 1'b0;
    end else begin
      s2_tag <= in_tag;
      if (in_tag.vld) begin
        s2_r    <= shr;
        s2_relu <= in_relu;
      end
    end
  end

  // ReLU zeroing is not a clip; only hitting a range limit counts.
  always_comb begin
    sat_hit = 1'b0;
    sat_val = s2_r[DATAW-1:0];
    if (s2_relu) begin
      if (s2_r[ACCW+1]) begin
        sat_val = '0;
      end else if (s2_r > UMAX) begin
        sat_val = '1;
        sat_hit = 1'b1;
      end
    end else begin
      if (s2_r > SMAX) begin
        sat_val = {1'b0, {(DATAW-1){1'b1}}};
        sat_hit = 1'b1;
      end else if (s2_r < SMIN) begin
        sat_val = {1'b1, {(DATAW-1){1'b0}}};
        sat_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_tag  <= '0;
      out_data <= '0;
      sat_cnt  <= '0;
    end else begin
      out_tag <= s2_tag;
      if (s2_tag.vld) begin
        out_data <= sat_val;
        if (sat_hit && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
      end
    end
  end
endmodule

// File: rtl/conv_requant_relu.sv
// Streaming requantiser: bias add + framing (S1), then round-shift and saturate.
// Config is shadowed on the first pixel of each frame.
module conv_requant_relu
  import nn_stream_pkg::*;
#(
  parameter int DATAW = DATAW_D,
  parameter int ACCW  = ACCW_D,
  parameter int SHW   = SHW_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_vld,
  input  logic [ACCW-1:0]  acc_data,
  input  logic [ACCW-1:0]  cfg_bias,
  input  logic [SHW-1:0]   cfg_shift,
  input  logic             cfg_relu_en,
  input  logic [15:0]      cfg_in_width,
  input  logic [15:0]      cfg_in_height,
  output logic             out_vld,
  output logic [DATAW-1:0] out_data,
  output logic             out_eol,
  output logic             out_eof,
  output logic [15:0]      sat_cnt
);
  logic [ACCW-1:0] sh_bias;
  logic [SHW-1:0]  sh_shift;
  logic            sh_relu;
  logic [15:0]     sh_w, sh_h;
  logic [15:0]     col, row;

  logic            first;
  logic [ACCW-1:0] eff_bias;
  logic [SHW-1:0]  eff_shift;
  logic            eff_relu;
  logic [15:0]     eff_w, eff_h, w_last, h_last;
  logic            eol, eof;

  frame_tag_t          s1_tag, o_tag;
  logic signed [ACCW:0] s1_sum;
  logic [SHW-1:0]       s1_shift;
  logic                 s1_relu;

  // The frame's first pixel uses the live config, later pixels the shadow.
  always_comb begin
    first     = (col == '0) && (row == '0);
    eff_bias  = first ? cfg_bias      : sh_bias;
    eff_shift = first ? cfg_shift     : sh_shift;
    eff_relu  = first ? cfg_relu_en   : sh_relu;
    eff_w     = first ? cfg_in_width  : sh_w;
    eff_h     = first ? cfg_in_height : sh_h;
    w_last    = (eff_w == '0) ? '0 : eff_w - 16'd1;
    h_last    = (eff_h == '0) ? '0 : eff_h - 16'd1;
    eol       = (col == w_last);
    eof       = eol && (row == h_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      sh_bias  <= '0;
      sh_shift <= '0;
      sh_relu  <= 1'b0;
      sh_w     <= '0;
      sh_h     <= '0;
      s1_tag   <= '0;
      s1_sum   <= '0;
      s1_shift <= '0;
      s1_relu  <= 1'b0;
    end else begin
      s1_tag <= '{vld: acc_vld, eol: acc_vld && eol, eof: acc_vld && eof};
      if (acc_vld) begin
        s1_sum   <= $signed({acc_data[ACCW-1], acc_data}) + $signed({eff_bias[ACCW-1], eff_bias});
        s1_shift <= eff_shift;
        s1_relu  <= eff_relu;
        if (first) begin
          sh_bias  <= cfg_bias;
          sh_shift <= cfg_shift;
          sh_relu  <= cfg_relu_en;
          sh_w     <= cfg_in_width;
          sh_h     <= cfg_in_height;
        end
        if (eol) begin
          col <= '0;
          row <= eof ? 16'd0 : row + 16'd1;
        end else begin
          col <= col + 16'd1;
        end
      end
    end
  end

  requant_round_sat #(.DATAW(DATAW), .ACCW(ACCW), .SHW(SHW)) u_rrs (
    .clk      (clk),
    .rst      (rst),
    .in_tag   (s1_tag),
    .in_sum   (s1_sum),
    .in_shift (s1_shift),
    .in_relu  (s1_relu),
    .out_tag  (o_tag),
    .out_data (out_data),
    .sat_cnt  (sat_cnt)
  );

  assign out_vld = o_tag.vld;
  assign out_eol = o_tag.eol;
  assign out_eof = o_tag.eof;
endmodule

// File: tb/tb_conv_requant_relu.sv
// Directed bench for conv_requant_relu with an arithmetic reference model
// scheduled by cycle and checked against the outputs every cycle.
module tb_conv_requant_relu;
  localparam int DATAW = 8;
  localparam int ACCW  = 24;
  localparam int SHW   = 5;
  localparam int NCYC  = 4096;

  logic             clk = 1'b0;
  logic             rst;
  logic             acc_vld;
  logic [ACCW-1:0]  acc_data;
  logic [ACCW-1:0]  cfg_bias;
  logic [SHW-1:0]   cfg_shift;
  logic             cfg_relu_en;
  logic [15:0]      cfg_in_width, cfg_in_height;
  logic             out_vld, out_eol, out_eof;
  logic [DATAW-1:0] out_data;
  logic [15:0]      sat_cnt;

  conv_requant_relu #(.DATAW(DATAW), .ACCW(ACCW), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .acc_vld(acc_vld), .acc_data(acc_data),
    .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .cfg_relu_en(cfg_relu_en),
    .cfg_in_width(cfg_in_width), .cfg_in_height(cfg_in_height),
    .out_vld(out_vld), .out_data(out_data), .out_eol(out_eol), .out_eof(out_eof),
    .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs indexed by the cycle in which they must appear.
  logic        exp_vld [NCYC];
  logic [7:0]  exp_data[NCYC];
  logic        exp_eol [NCYC];
  logic        exp_eof [NCYC];
  logic [15:0] exp_sat [NCYC];

  // Intended config; driven onto the ports only at a negedge.
  int c_bias, c_shift, c_relu, c_w, c_h;
  // Model state.
  int     m_col, m_row, m_sat;
  longint m_bias;
  int     m_shift, m_w, m_h;
  bit     m_relu;
  int     eol_seen, eof_seen;
  bit     done = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Spec arithmetic: floor((acc+bias + 2^(sh-1)) / 2^sh), then clamp.
  function automatic logic [7:0] requant(input longint acc, input longint bias,
                                         input int sh, input bit relu, output bit sat);
    longint s, r, d, t;
    logic [7:0] res;
    sat = 1'b0;
    s = acc + bias;
    if (sh == 0) r = s;
    else if (sh > ACCW) r = (s < 0) ? -1 : 0;
    else begin
      d = longint'(1) << sh;
      t = s + d / 2;
      r = (t >= 0) ? t / d : -((-t + d - 1) / d);
    end
    if (relu) begin
      if (r < 0) r = 0;
      else if (r > 255) begin r = 255; sat = 1'b1; end
    end else begin
      if (r > 127) begin r = 127; sat = 1'b1; end
      else if (r < -128) begin r = -128; sat = 1'b1; end
    end
    res = r[7:0];
    return res;
  endfunction

  task automatic apply_cfg();
    cfg_bias      = c_bias[ACCW-1:0];
    cfg_shift     = c_shift[SHW-1:0];
    cfg_relu_en   = c_relu[0];
    cfg_in_width  = c_w[15:0];
    cfg_in_height = c_h[15:0];
  endtask

  task automatic model_pixel(input int acc);
    int w, h, idx;
    bit s;
    if (m_col == 0 && m_row == 0) begin
      m_bias = longint'($signed(cfg_bias));
      m_shift = int'(cfg_shift);
      m_relu = cfg_relu_en;
      m_w = int'(cfg_in_width);
      m_h = int'(cfg_in_height);
    end
    w = (m_w == 0) ? 1 : m_w;
    h = (m_h == 0) ? 1 : m_h;
    idx = cyc + 3;
    exp_data[idx] = requant(longint'(acc), m_bias, m_shift, m_relu, s);
    if (s && m_sat < 65535) m_sat++;
    exp_vld[idx] = 1'b1;
    exp_sat[idx] = m_sat[15:0];
    exp_eol[idx] = (m_col == w - 1);
    exp_eof[idx] = (m_col == w - 1) && (m_row == h - 1);
    if (m_col == w - 1) begin
      m_col = 0;
      m_row = (m_row == h - 1) ? 0 : m_row + 1;
    end else m_col++;
  endtask

  task automatic send(input int acc, input int gap);
    repeat (gap) begin
      @(negedge clk);
      acc_vld = 1'b0;
      apply_cfg();
    end
    @(negedge clk);
    apply_cfg();
    acc_vld  = 1'b1;
    acc_data = acc[ACCW-1:0];
    model_pixel(acc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      acc_vld = 1'b0;
      apply_cfg();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    acc_vld = 1'b0;
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) exp_vld[cyc + i] = 1'b0;
    m_col = 0; m_row = 0; m_sat = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!done && cyc < NCYC - 8) begin
      check("out_vld", out_vld, exp_vld[cyc]);
      if (exp_vld[cyc]) begin
        check("out_data", out_data, exp_data[cyc]);
        check("out_eol", out_eol, exp_eol[cyc]);
        check("out_eof", out_eof, exp_eof[cyc]);
        check("sat_cnt", sat_cnt, exp_sat[cyc]);
      end
      if (out_vld && out_eol) eol_seen++;
      if (out_vld && out_eof) eof_seen++;
    end
  end

  initial begin
    bit s;
    int vals[8];
    int gaps[8];
    vals = '{100, 40, 200, 8, 12, 60, 1000, 20};
    gaps = '{0, 2, 1, 0, 3, 0, 1, 2};
    for (int i = 0; i < NCYC; i++) begin
      exp_vld[i] = 1'b0; exp_data[i] = '0; exp_eol[i] = 1'b0;
      exp_eof[i] = 1'b0; exp_sat[i] = '0;
    end
    m_col = 0; m_row = 0; m_sat = 0;
    m_bias = 0; m_shift = 0; m_relu = 1'b0; m_w = 1; m_h = 1;
    c_bias = 0; c_shift = 0; c_relu = 1; c_w = 1; c_h = 1;
    apply_cfg();
    rst = 1'b1; acc_vld = 1'b0; acc_data = '0;

    // Pin the model to hand-computed results.
    check("pin_344_sh4", requant(344, 0, 4, 1, s), 22);
    check("pin_neg100_raw", requant(-100, 0, 0, 0, s), 8'h9C);
    check("pin_5000_relu", requant(5000, 0, 0, 1, s), 8'hFF);
    check("pin_5000_sat", s, 1);
    check("pin_m5000", requant(-5000, 0, 0, 0, s), 8'h80);
    check("pin_m3_sh1", requant(-3, 0, 1, 0, s), 8'hFF);
    check("pin_3_bm1", requant(3, -1, 1, 0, s), 1);

    repeat (3) @(negedge clk);
    check("rst_vld", out_vld, 0);
    check("rst_data", out_data, 0);
    check("rst_eol", out_eol, 0);
    check("rst_eof", out_eof, 0);
    check("rst_sat", sat_cnt, 0);
    rst = 1'b0;
    idle(2);

    // 1: latency and rounding
    c_bias = 0; c_shift = 4; c_relu = 1;
    send(344, 0);
    idle(1); check("t1_lat1", out_vld, 0);
    idle(1); check("t1_lat2", out_vld, 0);
    idle(1); check("t1_lat3_vld", out_vld, 1); check("t1_data", out_data, 22);
    idle(2);

    // 2, 3: ReLU zeroing vs clipping (one pixel per frame)
    c_shift = 0; send(-100, 0);
    c_relu = 0;  send(-100, 0);
    c_relu = 1;  send(5000, 0);
    c_relu = 0;  send(-5000, 0);
    idle(5);
    check("t3_sat_cnt", sat_cnt, 2);

    // 4: shift by one, rounding both signs, negative bias
    c_shift = 1; c_relu = 0; c_bias = 0;
    send(3, 0); send(-3, 0);
    c_bias = -1; send(3, 1);
    // Shifts at or beyond the sum width
    c_bias = 0; c_shift = 31; send(5, 0); send(-5, 0);
    c_shift = 25; send(-5, 0); send(5, 2);
    idle(5);

    // 5: framing with gaps, mid-frame config change ignored
    c_w = 4; c_h = 2; c_shift = 2; c_relu = 1; c_bias = 0;
    idle(1);
    eol_seen = 0; eof_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) c_shift = 0;
      send(vals[i], gaps[i]);
    end
    idle(6);
    check("t5_eol_count", eol_seen, 2);
    check("t5_eof_count", eof_seen, 1);

    // 6: reset mid-frame with pixels in flight
    c_shift = 1;
    send(10, 0); send(20, 0); send(30, 0);
    do_reset();
    check("t6_sat_cleared", sat_cnt, 0);
    c_w = 1; c_h = 1; c_shift = 3; c_bias = 0; c_relu = 1;
    idle(2);
    send(80, 0);
    idle(6);

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
